// File: rtl/led_scan.sv
// rtl/led_scan.sv - four-digit multiplexed seven-segment driver with frame-synchronous commit
module led_scan #(
    parameter int SCAN_DIV  = 16,
    parameter int BLANK_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        data_vld,
    output logic [7:0]  LED_O,
    output logic [3:0]  LED_SEL,
    output logic        indi
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [19:0]      shadow_q, shadow_d;
    logic [19:0]      disp_q, disp_d;
    logic             pending_q, pending_d;
    logic [7:0]       led_q, led_d;
    logic [3:0]       sel_q, sel_d;
    logic             indi_q, indi_d;
    logic             slot_end;
    logic             commit;
    logic [3:0]       nibble;
    logic             dp_bit;

    // Active-low segments a..g in bits [6:0]
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        commit    = slot_end && (idx_q == 2'd3) && pending_q;
        cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d     = idx_q + {1'b0, slot_end};
        shadow_d  = data_vld ? {dp_in, data_in} : shadow_q;
        disp_d    = commit ? shadow_q : disp_q;
        indi_d    = indi_q ^ commit;
        // A strobe in the commit cycle re-arms pending for the following frame
        pending_d = data_vld ? 1'b1 : (commit ? 1'b0 : pending_q);
        nibble    = disp_q[{idx_q, 2'b00} +: 4];
        dp_bit    = disp_q[5'd16 + {3'b000, idx_q}];
        sel_d     = (cnt_q < CNT_BLANK) ? 4'hF : ~(4'b0001 << idx_q);
        led_d     = {~dp_bit, hex_seg(nibble)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            led_q     <= 8'hFF;
            sel_q     <= 4'hF;
            indi_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            led_q     <= led_d;
            sel_q     <= sel_d;
            indi_q    <= indi_d;
        end
    end

    assign LED_O   = led_q;
    assign LED_SEL = sel_q;
    assign indi    = indi_q;

endmodule

// File: tb/tb_led_scan.sv
// tb/tb_led_scan.sv - directed and random checks for led_scan
module tb_led_scan;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        data_vld;
    logic [7:0]  LED_O;
    logic [3:0]  LED_SEL;
    logic        indi;

    int   checks   = 0;
    int   failures = 0;
    int   p        = 0;
    logic exp_indi = 1'b0;
    logic [15:0] sel_tab = 16'h7BDE;

    led_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .data_vld (data_vld),
        .LED_O    (LED_O),
        .LED_SEL  (LED_SEL),
        .indi     (indi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        p++;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_vld = 1'b0; data_in = '0; dp_in = '0;
        #3 rst = 1'b0;
        #1;
        checks++; if (LED_SEL !== 4'hF) begin failures++; $display("FAIL reset_sel got=%h exp=F", LED_SEL); end
        checks++; if (LED_O !== 8'hFF) begin failures++; $display("FAIL reset_led got=%h exp=FF", LED_O); end
        checks++; if (indi !== 1'b0) begin failures++; $display("FAIL reset_indi got=%b exp=0", indi); end
        repeat (2) @(negedge clk);
        checks++; if (LED_O !== 8'hFF) begin failures++; $display("FAIL reset_hold_led got=%h exp=FF", LED_O); end
        rst = 1'b1;
        p = 0;
        exp_indi = 1'b0;
    endtask

    task automatic test_idle();
        for (int k = 1; k <= 32; k++) begin
            int c, i;
            logic [3:0] es;
            tick();
            c = (k - 1) % 8;
            i = (k - 1) / 8;
            es = (c < 2) ? 4'hF : sel_tab[i*4 +: 4];
            checks++; if (LED_SEL !== es) begin failures++; $display("FAIL idle_sel k=%0d got=%h exp=%h", k, LED_SEL, es); end
            checks++; if (LED_O !== 8'hC0) begin failures++; $display("FAIL idle_led k=%0d got=%h exp=C0", k, LED_O); end
            checks++; if (indi !== 1'b0) begin failures++; $display("FAIL idle_indi k=%0d got=%b exp=0", k, indi); end
        end
    endtask

    task automatic test_commit();
        logic [31:0] led_tab;
        led_tab = {8'hF9, 8'h24, 8'h88, 8'h8E};
        data_in = 16'h12AF; dp_in = 4'b0100; data_vld = 1'b1;
        tick();
        data_vld = 1'b0;
        while (p % 32 != 0) tick();
        exp_indi = ~exp_indi;
        checks++; if (indi !== exp_indi) begin failures++; $display("FAIL commit_indi got=%b exp=%b", indi, exp_indi); end
        for (int k = 1; k <= 32; k++) begin
            int c, i;
            tick();
            c = (k - 1) % 8;
            i = (k - 1) / 8;
            if (c == 0) begin
                checks++; if (LED_SEL !== 4'hF) begin failures++; $display("FAIL commit_blank_sel i=%0d got=%h exp=F", i, LED_SEL); end
                checks++; if (LED_O !== led_tab[i*8 +: 8]) begin failures++; $display("FAIL commit_blank_led i=%0d got=%h exp=%h", i, LED_O, led_tab[i*8 +: 8]); end
            end
            if (c == 7) begin
                checks++; if (LED_SEL !== sel_tab[i*4 +: 4]) begin failures++; $display("FAIL commit_sel i=%0d got=%h exp=%h", i, LED_SEL, sel_tab[i*4 +: 4]); end
                checks++; if (LED_O !== led_tab[i*8 +: 8]) begin failures++; $display("FAIL commit_led i=%0d got=%h exp=%h", i, LED_O, led_tab[i*8 +: 8]); end
            end
        end
    endtask

    task automatic test_two_strobes();
        data_in = 16'h1111; dp_in = 4'b0000; data_vld = 1'b1;
        tick();
        data_vld = 1'b0;
        repeat (3) tick();
        data_in = 16'h2222; data_vld = 1'b1;
        tick();
        data_vld = 1'b0;
        while (p % 32 != 0) tick();
        exp_indi = ~exp_indi;
        checks++; if (indi !== exp_indi) begin failures++; $display("FAIL two_indi got=%b exp=%b", indi, exp_indi); end
        for (int k = 1; k <= 32; k++) begin
            tick();
            if ((k - 1) % 8 == 7) begin
                checks++; if (LED_O !== 8'hA4) begin failures++; $display("FAIL two_led k=%0d got=%h exp=A4", k, LED_O); end
            end
        end
        checks++; if (indi !== exp_indi) begin failures++; $display("FAIL two_hold_indi got=%b exp=%b", indi, exp_indi); end
    endtask

    task automatic test_back_to_back();
        data_in = 16'h3333; dp_in = 4'b0000; data_vld = 1'b1;
        tick();
        data_vld = 1'b0;
        while (p % 32 != 31) tick();
        data_in = 16'h4444; data_vld = 1'b1;
        tick();
        data_vld = 1'b0;
        exp_indi = ~exp_indi;
        checks++; if (indi !== exp_indi) begin failures++; $display("FAIL b2b_first_indi got=%b exp=%b", indi, exp_indi); end
        for (int k = 1; k <= 32; k++) begin
            tick();
            if ((k - 1) % 8 == 7) begin
                checks++; if (LED_O !== 8'hB0) begin failures++; $display("FAIL b2b_first_led k=%0d got=%h exp=B0", k, LED_O); end
            end
        end
        exp_indi = ~exp_indi;
        checks++; if (indi !== exp_indi) begin failures++; $display("FAIL b2b_second_indi got=%b exp=%b", indi, exp_indi); end
        for (int k = 1; k <= 32; k++) begin
            tick();
            if ((k - 1) % 8 == 7) begin
                checks++; if (LED_O !== 8'h99) begin failures++; $display("FAIL b2b_second_led k=%0d got=%h exp=99", k, LED_O); end
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (19) tick();
        checks++; if (LED_SEL !== 4'hB) begin failures++; $display("FAIL mid_pre_sel got=%h exp=B", LED_SEL); end
        #2 rst = 1'b0;
        data_in = 16'hFFFF; dp_in = 4'hF; data_vld = 1'b1;
        #1;
        checks++; if (LED_SEL !== 4'hF) begin failures++; $display("FAIL mid_sel got=%h exp=F", LED_SEL); end
        checks++; if (LED_O !== 8'hFF) begin failures++; $display("FAIL mid_led got=%h exp=FF", LED_O); end
        checks++; if (indi !== 1'b0) begin failures++; $display("FAIL mid_indi got=%b exp=0", indi); end
        repeat (3) @(negedge clk);
        data_vld = 1'b0;
        rst = 1'b1;
        p = 0;
        exp_indi = 1'b0;
        repeat (2) tick();
        checks++; if (LED_SEL !== 4'hF) begin failures++; $display("FAIL mid_rel_blank got=%h exp=F", LED_SEL); end
        tick();
        checks++; if (LED_SEL !== 4'hE) begin failures++; $display("FAIL mid_rel_sel got=%h exp=E", LED_SEL); end
        checks++; if (LED_O !== 8'hC0) begin failures++; $display("FAIL mid_rel_led got=%h exp=C0", LED_O); end
        while (p % 32 != 0) tick();
        checks++; if (indi !== 1'b0) begin failures++; $display("FAIL mid_no_commit got=%b exp=0", indi); end
    endtask

    task automatic test_random();
        int m_cnt = 0, m_idx = 0, commits = 0, toggles = 0, bad = 0;
        logic m_pend = 1'b0;
        logic prev;
        logic m_commit;
        prev = indi;
        for (int n = 0; n < 1000; n++) begin
            data_vld = ($urandom_range(0, 7) == 0);
            data_in  = 16'($urandom);
            dp_in    = 4'($urandom);
            m_commit = (m_cnt == 7) && (m_idx == 3) && m_pend;
            if (m_commit) commits++;
            m_pend = data_vld ? 1'b1 : (m_commit ? 1'b0 : m_pend);
            if (m_cnt == 7) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
            tick();
            if (indi !== prev) toggles++;
            prev = indi;
            if ($countones(~LED_SEL) > 1) bad++;
        end
        data_vld = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL rand_onehot violations=%0d exp=0", bad); end
        checks++; if (toggles != commits) begin failures++; $display("FAIL rand_toggles got=%0d exp=%0d", toggles, commits); end
        checks++; if (indi !== commits[0]) begin failures++; $display("FAIL rand_indi got=%b exp=%b", indi, commits[0]); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_commit();
        test_two_strobes();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_scan.md
Name: led_scan

Overview:
- Four-digit multiplexed seven-segment display driver downstream of the CPU core's debug/data output.
- Takes a 16-bit value plus decimal-point mask, double-buffers it, and commits the new value only on frame boundaries, so a digit never shows half-old, half-new data.
- Time-multiplexes the four digits with an anti-ghosting blank window.
- Drives LED_O, LED_SEL and indi on the board top.

Parameters:
- SCAN_DIV, 16, clk cycles per digit slot; must be ≥ 2. Board builds override it to ~50000.
- BLANK_CYC, 2, cycles at the start of each slot with all digits off; must be < SCAN_DIV.
- CNT_W, 16, refresh counter width; must satisfy 2^CNT_W ≥ SCAN_DIV.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  16  value to display; [3:0] is the rightmost digit.
- dp_in  in  4  decimal-point enables; bit i belongs to digit i.
- data_vld  in  1  single-cycle strobe that captures data_in/dp_in into the shadow register.
- LED_O  out  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
- LED_SEL  out  4  digit enables, active-low, registered.
- indi  out  1  toggles on every commit of a new value, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - LED_O=8'hFF, LED_SEL=4'hF, indi=0.
  - cnt=0, idx=0.
  - shadow=0, disp=0, pending=0.
- Refresh counter:
  - cnt runs 0..SCAN_DIV-1 and then wraps to 0.
  - When cnt=SCAN_DIV-1, idx increments mod 4 (3→0).
- Capture: when data_vld=1, shadow ← {dp_in, data_in} and pending ← 1. The last strobe before a commit wins.
- Commit:
  - Occurs when cnt=SCAN_DIV-1, idx=3 and pending=1.
  - Actions: disp ← shadow, pending ← 0, indi toggles.
  - If data_vld is also high in that cycle, the commit uses the old shadow, the new data is captured, and pending stays 1. The next frame commits it.
- Output register (one cycle after the cnt/idx state that produces it):
  - LED_SEL = 4'hF if cnt < BLANK_CYC; otherwise ~(4'b0001 << idx).
  - LED_O[6:0] = hex pattern of disp nibble idx.
  - LED_O[7] = ~dp bit idx.
  - LED_O is valid even while LED_SEL is blanked.
- Hex patterns for LED_O[6:0], active-low, shown with LED_O[7]=1:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Boundary conditions:
  - Exactly one LED_SEL bit is low outside the blank window; never more than one.
  - No commit occurs when pending=0, and indi holds.
  - If rst is asserted mid-frame, all state returns to reset values immediately. After release, scanning restarts at idx=0, cnt=0.
  - A data_vld during reset is ignored.

Test Plan:
- Reset, then release with no data_vld, SCAN_DIV=8, BLANK_CYC=2:
  - LED_SEL follows F,F,E,E,E,E,E,E, then F,F,D… per slot.
  - LED_O=C0 on every slot; indi stays 0.
- data_vld with data_in=16'h12AF, dp_in=4'b0100:
  - After the next idx=3 slot ends, indi=1.
  - The frame shows SEL E→8E, D→88, B→24 (dp on), 7→F9.
- Two strobes inside one frame (16'h1111 then 16'h2222): only 2222 is committed, and indi toggles once.
- data_vld coinciding with the commit cycle:
  - The earlier value commits and indi toggles.
  - The strobed value commits one frame later, and indi toggles again.
- Assert rst in the middle of an idx=2 slot:
  - LED_SEL=F, LED_O=FF and indi=0 immediately, without waiting for a clock.
  - After release, the first active slot is LED_SEL=E.
- Over 1000 random cycles with random strobes:
  - popcount(~LED_SEL) ≤ 1 at all times.
  - indi toggles equal the number of commits.
